// File: rtl/shift_pkg.sv
// shift_pkg: shared operation encodings and FSM state type for the iterative shifter
package shift_pkg;
  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_ROTL = 2'b10,
    SH_SRA  = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of acc by k (0..STEP) bits in the selected mode
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] res
);
  logic [KW:0][WIDTH-1:0] st;
  assign st[0] = acc;
  for (genvar i = 0; i < KW; i++) begin : g_stage
    localparam int S = 2 ** i;
    logic [2*WIDTH-1:0] l, r;
    assign l = {st[i], st[i]} << S;
    assign r = {{WIDTH{op == SH_SRA && sign}}, st[i]} >> S;
    assign st[i+1] = !k[i] ? st[i] :
                     op == SH_SLL  ? st[i] << S :
                     op == SH_ROTL ? l[2*WIDTH-1:WIDTH] : r[WIDTH-1:0];
  end
  assign res = st[KW];
endmodule

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA/ROTL unit with start/busy/done handshake
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);
  localparam int KW = $clog2(STEP) + 1;
  if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_chk
    $error("shift_unit_iter: STEP must be a power of two in 1..WIDTH");
  end
  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, stepped;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         opr;
  logic               signr, accept, last;
  logic [KW-1:0]      k;
  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .acc (acc),
    .k   (k),
    .op  (opr),
    .sign(signr),
    .res (stepped)
  );
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  assign accept = start && state != SHIFT;
  // per-cycle step size and next-state selection
  always_comb begin
    k        = int'(cnt) >= STEP ? KW'(STEP) : KW'(cnt);
    last     = int'(cnt) <= STEP;
    state_nx = accept ? (shamt != '0 ? SHIFT : DONE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // operand capture, iterative shifting and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      opr   <= '0;
      signr <= 1'b0;
      dout  <= '0;
    end else if (accept) begin
      acc   <= din;
      cnt   <= shamt;
      opr   <= op;
      signr <= din[WIDTH-1];
      if (shamt == '0) dout <= din;
    end else if (state == SHIFT) begin
      acc <= stepped;
      cnt <= cnt - SHAMT_W'(k);
      if (last) dout <= stepped;
    end
  end
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed vectors plus a cycle-level reference model for two shifter configs
module tb_shift_unit_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start;
  logic [1:0]  op;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic [1:0]  busy, done;
  logic [31:0] dout [2];
  int total = 0;
  int bad = 0;
  int steps [2] = '{4, 1};
  logic        m_busy [2];
  logic        m_done [2];
  logic [31:0] m_dout [2];
  logic [31:0] m_res [2];
  int          rem [2];

  always #5 clk = ~clk;

  shift_unit_iter #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .op(op), .din(din), .shamt(shamt),
    .busy(busy[0]), .done(done[0]), .dout(dout[0])
  );
  shift_unit_iter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op), .din(din), .shamt(shamt),
    .busy(busy[1]), .done(done[1]), .dout(dout[1])
  );

  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] d, int s);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return 32'($signed(d) >>> s);
      default: return s == 0 ? d : (d << s) | (d >> (32 - s));
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference: busy for ceil(shamt/STEP) cycles after accept, then one done cycle
  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_busy[u] <= 1'b0;
        m_done[u] <= 1'b0;
        m_dout[u] <= '0;
        rem[u]    <= 0;
      end else if (start[u] && !m_busy[u]) begin
        int c;
        c = (int'(shamt) + steps[u] - 1) / steps[u];
        m_res[u]  <= ref_shift(op, din, int'(shamt));
        rem[u]    <= c;
        m_busy[u] <= c != 0;
        m_done[u] <= c == 0;
        if (c == 0) m_dout[u] <= din;
      end else if (m_busy[u]) begin
        rem[u] <= rem[u] - 1;
        if (rem[u] == 1) begin
          m_busy[u] <= 1'b0;
          m_done[u] <= 1'b1;
          m_dout[u] <= m_res[u];
        end
      end else begin
        m_done[u] <= 1'b0;
      end
    end
  end

  // every-cycle comparison of both DUTs against the reference
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("cyc_busy%0d", u), 32'(busy[u]), 32'(m_busy[u]));
        check($sformatf("cyc_done%0d", u), 32'(done[u]), 32'(m_done[u]));
        check($sformatf("cyc_dout%0d", u), dout[u], m_dout[u]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    din   = $urandom;
    op    = 2'($urandom);
    shamt = 5'($urandom);
  endtask

  task automatic run(int u, logic [1:0] o, logic [31:0] d, logic [4:0] s,
                     logic [31:0] exp, int lat, int bexp, bit hold);
    int n = 1;
    int b = 0;
    op = o;
    din = d;
    shamt = s;
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    scramble();
    while (!done[u] && n < 40) begin
      b += int'(busy[u]);
      tick();
      n++;
    end
    check($sformatf("latency_u%0d_op%0d_s%0d", u, o, s), n, lat);
    check($sformatf("dout_u%0d_op%0d_s%0d", u, o, s), dout[u], exp);
    check($sformatf("busy_cycles_u%0d_op%0d_s%0d", u, o, s), b, bexp);
    if (!hold) tick();
  endtask

  initial begin
    int n;
    int dn;
    start = '0;
    op = '0;
    din = '0;
    shamt = '0;
    #2;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_busy%0d", u), 32'(busy[u]), 0);
      check($sformatf("reset_done%0d", u), 32'(done[u]), 0);
      check($sformatf("reset_dout%0d", u), dout[u], 0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    run(0, 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2, 1, 0);
    run(0, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, 8, 0);
    run(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 8, 0);
    run(0, 2'b10, 32'h8000_0001, 5'd1, 32'h0000_0003, 2, 1, 0);
    run(0, 2'b10, 32'h1234_5678, 5'd8, 32'h3456_7812, 3, 2, 0);
    run(0, 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0, 0);
    run(1, 2'b11, 32'hF000_0000, 5'd3, 32'hFE00_0000, 4, 3, 0);
    // starts while busy must be ignored
    op = 2'b11;
    din = 32'h8000_0000;
    shamt = 5'd31;
    start[0] = 1'b1;
    tick();
    n = 1;
    for (int j = 0; j < 3; j++) begin
      din = 32'h0000_00F0 + 32'(j);
      op = 2'b00;
      shamt = 5'd1;
      tick();
      start[0] = 1'b0;
      tick();
      start[0] = 1'b1;
      n += 2;
    end
    start[0] = 1'b0;
    while (!done[0] && n < 40) begin
      tick();
      n++;
    end
    check("ignored_start_latency", n, 9);
    check("ignored_start_dout", dout[0], 32'hFFFF_FFFF);
    tick();
    // reset in the middle of an operation
    op = 2'b00;
    din = 32'h0000_FFFF;
    shamt = 5'd20;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_done", 32'(done[0]), 0);
    check("abort_dout", dout[0], 0);
    #1;
    rst = 1'b0;
    dn = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      dn += int'(done[0]);
    end
    check("abort_no_done", dn, 0);
    // back-to-back accept in the done cycle
    run(0, 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2, 1, 1);
    run(0, 2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F, 2, 1, 0);
    run(1, 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 6, 5, 1);
    run(1, 2'b10, 32'h8000_0000, 5'd5, 32'h0000_0010, 6, 5, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
